// File: rtl/ir_packet_gen.sv
// IR car-remote packet generator: START, CAR and four direction-bit bursts, each followed by a gap,
// all gated by a square carrier. Define IR_AUTO_REPEAT_EN to add the REPEAT input for back-to-back packets.
module ir_packet_gen #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int CARRIER_FREQ   = 36_000,
  parameter int START_BURST    = 191,
  parameter int CAR_BURST      = 47,
  parameter int GAP            = 25,
  parameter int ASSERT_BURST   = 47,
  parameter int DEASSERT_BURST = 22
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND,
  input  logic [3:0] COMMAND,
`ifdef IR_AUTO_REPEAT_EN
  input  logic       REPEAT,
`endif
  output logic       BUSY,
  output logic       DONE,
  output logic       IR_LED
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PERIOD  = CLK_FREQ / CARRIER_FREQ;
  localparam int HALF    = PERIOD / 2;
  localparam int MAX_LEN = max2(max2(START_BURST, CAR_BURST),
                                max2(GAP, max2(ASSERT_BURST, DEASSERT_BURST)));
  localparam int CW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PW      = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    seg_q, seg_d;      // burst index: 0 start, 1 car, 2..5 R/L/B/F
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] per_q, per_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          done_d, done_q;
  logic          led_d, led_q;
  logic          repeat_req;
  int            burst_len;
  int            seg_len;
  logic          period_end;
  logic          seg_end;

`ifdef IR_AUTO_REPEAT_EN
  assign repeat_req = REPEAT;
`else
  assign repeat_req = 1'b0;
`endif

  always_comb begin
    case (seg_q)
      3'd0:    burst_len = START_BURST;
      3'd1:    burst_len = CAR_BURST;
      3'd2:    burst_len = cmd_q[0] ? ASSERT_BURST : DEASSERT_BURST;
      3'd3:    burst_len = cmd_q[1] ? ASSERT_BURST : DEASSERT_BURST;
      3'd4:    burst_len = cmd_q[2] ? ASSERT_BURST : DEASSERT_BURST;
      default: burst_len = cmd_q[3] ? ASSERT_BURST : DEASSERT_BURST;
    endcase
  end

  // NOTE: every variable written below gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cyc_d   = cyc_q;
    per_d   = per_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;

    seg_len    = (state_q == ST_GAP) ? GAP : burst_len;
    period_end = (int'(cyc_q) == PERIOD - 1);
    seg_end    = period_end && (int'(per_q) == seg_len - 1);

    case (state_q)
      ST_IDLE: begin
        if (SEND) begin
          state_d = ST_BURST;
          seg_d   = 3'd0;
          cyc_d   = '0;
          per_d   = '0;
          cmd_d   = COMMAND;
        end
      end
      default: begin
        if (seg_end) begin
          cyc_d = '0;
          per_d = '0;
          if (state_q == ST_BURST) begin
            state_d = ST_GAP;
          end else if (seg_q == 3'd5) begin
            done_d = 1'b1;
            if (repeat_req) begin
              state_d = ST_BURST;
              seg_d   = 3'd0;
              cmd_d   = COMMAND;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_BURST;
            seg_d   = seg_q + 3'd1;
          end
        end else if (period_end) begin
          cyc_d = '0;
          per_d = per_q + PW'(1);
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase

    // The LED register takes the level of the cycle that is about to start.
    led_d = (state_d == ST_BURST) && (int'(cyc_d) < HALF);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      seg_q   <= '0;
      cyc_q   <= '0;
      per_q   <= '0;
      cmd_q   <= '0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cyc_q   <= cyc_d;
      per_q   <= per_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign IR_LED = led_q;

endmodule

// File: tb/tb_ir_packet_gen.sv
// Scoreboard bench for ir_packet_gen: the driver pushes one expected packet per accepted SEND and a monitor
// pops and compares the LED trace, busy length and pulse count against a segment-list model.
module tb_ir_packet_gen;

  localparam int CLK_F  = 1000;
  localparam int CAR_F  = 100;
  localparam int P      = CLK_F / CAR_F;
  localparam int START  = 3;
  localparam int CARB   = 2;
  localparam int GAPL   = 2;
  localparam int ASSERT = 2;
  localparam int DEASRT = 1;

  typedef struct {
    logic [3:0] cmd;
    int         cycles;
    int         pulses;
    logic       busy_at_done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [3:0] command;
  logic       busy, done, ir_led;
`ifdef IR_AUTO_REPEAT_EN
  logic       rep;
`endif

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   idle_led_err = 0;

  always #5 clk = ~clk;

  ir_packet_gen #(
    .CLK_FREQ(CLK_F), .CARRIER_FREQ(CAR_F), .START_BURST(START), .CAR_BURST(CARB),
    .GAP(GAPL), .ASSERT_BURST(ASSERT), .DEASSERT_BURST(DEASRT)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .SEND(send),
    .COMMAND(command),
`ifdef IR_AUTO_REPEAT_EN
    .REPEAT(rep),
`endif
    .BUSY(busy),
    .DONE(done),
    .IR_LED(ir_led)
  );

  task automatic check(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: packet as six bursts, each followed by a gap, all in carrier periods.
  function automatic int burst_len(input logic [3:0] c, input int i);
    if (i == 0) return START;
    if (i == 1) return CARB;
    return c[i-2] ? ASSERT : DEASRT;
  endfunction

  function automatic int pulse_cnt(input logic [3:0] c);
    int s = 0;
    for (int i = 0; i < 6; i++) s += burst_len(c, i);
    return s;
  endfunction

  function automatic int pkt_len(input logic [3:0] c);
    return P * (pulse_cnt(c) + 6 * GAPL);
  endfunction

  function automatic logic model_led(input logic [3:0] c, input int t_in);
    int t;
    int b;
    t = t_in;
    for (int i = 0; i < 6; i++) begin
      b = burst_len(c, i) * P;
      if (t < b) return ((t % P) < (P / 2));
      t -= b;
      if (t < GAPL * P) return 1'b0;
      t -= GAPL * P;
    end
    return 1'b0;
  endfunction

  task automatic set_repeat(input logic v);
`ifdef IR_AUTO_REPEAT_EN
    rep = v;
`else
    if (v) $display("note: repeat requested without IR_AUTO_REPEAT_EN");
`endif
  endtask

  task automatic idle(input int n);
    send = 1'b0;
    command = 4'($urandom);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Starts in an idle cycle, accepts first_c, runs cnt packets (cnt>1 chains with REPEAT),
  // and returns in the DONE cycle of the last one. abort_at>0 resets during that cycle of packet 0.
  task automatic run_packets(input logic [3:0] first_c, input int cnt, input bit hold, input int abort_at);
    logic [3:0] c;
    logic [3:0] c_next;
    int         n;
    exp_t       e;
    c = first_c;
    set_repeat(cnt > 1);
    send = 1'b1;
    command = c;
    @(posedge clk); #1;
    for (int p = 0; p < cnt; p++) begin
      n = pkt_len(c);
      e.cmd = c; e.cycles = n; e.pulses = pulse_cnt(c); e.busy_at_done = (p < cnt - 1);
      exp_q.push_back(e);
      set_repeat(p < cnt - 1);
      c_next = 4'($urandom);
      for (int k = 1; k <= n; k++) begin
        if (abort_at == k) begin
          check("pre_reset_led", int'(ir_led), int'(model_led(c, k - 1)));
          rst_n = 1'b0;
          #1;
          check("reset_busy", int'(busy), 0);
          check("reset_done", int'(done), 0);
          check("reset_led", int'(ir_led), 0);
          exp_q.delete();
          send = 1'b0;
          repeat (2) begin
            @(posedge clk); #1;
          end
          rst_n = 1'b1;
          return;
        end
        send = hold ? 1'b1 : 1'($urandom_range(0, 1));
        command = (k == n && p < cnt - 1) ? c_next : 4'($urandom);
        @(posedge clk); #1;
      end
      c = c_next;
    end
    set_repeat(1'b0);
  endtask

  // Monitor: pops an expectation when a packet starts, compares when DONE appears.
  initial begin : monitor
    int   k;
    int   pulses;
    int   mism;
    logic prev_led;
    bit   have;
    exp_t cur;
    k = 0; pulses = 0; mism = 0; prev_led = 1'b0; have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0; pulses = 0; mism = 0; prev_led = 1'b0; have = 1'b0;
      end else begin
        if (done) begin
          if (!have) begin
            check("done_without_packet", 1, 0);
          end else begin
            check("busy_cycles", k, cur.cycles);
            check("carrier_pulses", pulses, cur.pulses);
            check("led_trace_errors", mism, 0);
            check("busy_in_done_cycle", int'(busy), int'(cur.busy_at_done));
          end
          k = 0; pulses = 0; mism = 0; prev_led = 1'b0; have = 1'b0;
        end else if (!busy && have) begin
          check("busy_dropped_without_done", k, cur.cycles);
          k = 0; pulses = 0; mism = 0; prev_led = 1'b0; have = 1'b0;
        end
        if (busy) begin
          if (!have) begin
            if (exp_q.size() == 0) begin
              check("unexpected_busy", 1, 0);
            end else begin
              cur = exp_q.pop_front();
              have = 1'b1;
            end
          end
          if (have) begin
            k++;
            if (ir_led !== model_led(cur.cmd, k - 1)) begin
              if (mism == 0)
                $display("led differs at packet cycle %0d cmd=%b: got %b", k, cur.cmd, ir_led);
              mism++;
            end
            if (ir_led === 1'b1 && prev_led === 1'b0) pulses++;
            prev_led = ir_led;
          end
        end else if (ir_led !== 1'b0) begin
          idle_led_err++;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    send = 1'b0;
    command = 4'b0000;
`ifdef IR_AUTO_REPEAT_EN
    rep = 1'b0;
`endif
    #12;
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_led", int'(ir_led), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    run_packets(4'b1001, 1, 1'b0, 0);
    idle(3);
    run_packets(4'b0000, 1, 1'b0, 0);
    idle(1);
    run_packets(4'b1111, 1, 1'b1, 0);
    run_packets(4'b1111, 1, 1'b1, 0);
    run_packets(4'b0110, 1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      run_packets(4'($urandom), 1, 1'($urandom_range(0, 1)), 0);
    end
    idle(2);
    run_packets(4'b1001, 1, 1'b0, 101);
    idle(3);
    run_packets(4'b1001, 1, 1'b0, 0);
`ifdef IR_AUTO_REPEAT_EN
    idle(2);
    run_packets(4'b0001, 3, 1'b0, 0);
`endif
    idle(5);

    check("idle_led_errors", idle_led_err, 0);
    check("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
